// File: rtl/usb_uart_defs_pkg.sv
// Shared UART definitions for the USB status serial path.
// Holds transmitter state encodings, default clock/baud values and the
// bit-period divider computation. A future UART receiver reuses this package.
package usb_uart_defs_pkg;

  localparam int unsigned DEF_CLK_HZ = 48_000_000;
  localparam int unsigned DEF_BAUD   = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int unsigned DEF_DIV = calc_div(DEF_CLK_HZ, DEF_BAUD);

endpackage

// File: rtl/usb_baud_tick.sv
// Bit-period timer for the status UART.
// Counts 0..DIV-1 and wraps, so bit boundaries never drift.
// Ports:
//   clk48        system clock
//   rst          synchronous active-high reset
//   restart      start a fresh bit period; counter is 0 in the next cycle
//   tick         high during the last cycle of each bit period
//   tick_next_c  high when the next cycle is the last of a bit period
//                (ignores a simultaneous restart)
module usb_baud_tick
  import usb_uart_defs_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk48,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt;

  assign tick_next_c = (cnt == PRE);

  // Free-running wrap counter; tick is registered so it aligns with cnt == LAST.
  always_ff @(posedge clk48) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= tick_next_c;
    end
  end

endmodule

// File: rtl/usb_status_uart_tx.sv
// Byte-pull 8N1 UART transmitter draining the USB annunciator's status
// character stream onto the debug serial line.
// Ports:
//   clk48       system clock (48 MHz)
//   rst         synchronous active-high reset
//   en          streaming enable, honoured only at frame boundaries
//   q           character from annunciator, valid with dv
//   dv          annunciator data-valid strobe
//   inc         one-cycle next-character request
//   tx          serial output, idle high
//   busy        high from request through end of stop bit
//   frame_done  one-cycle pulse in the last stop-bit cycle
module usb_status_uart_tx
  import usb_uart_defs_pkg::*;
#(
  parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
  parameter int unsigned BAUD    = DEF_BAUD,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] q,
  input  logic       dv,
  output logic       inc,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned WW  = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  tx_state_e     state, state_d;
  logic [7:0]    shift, shift_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [WW-1:0] wait_cnt, wait_cnt_d;
  logic          inc_d, tx_d, busy_d, frame_done_d;
  logic          restart, tick, tick_next;

  usb_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .clk48      (clk48),
    .rst        (rst),
    .restart    (restart),
    .tick       (tick),
    .tick_next_c(tick_next)
  );

  // State and registered outputs.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      wait_cnt   <= '0;
      inc        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      bit_idx    <= bit_idx_d;
      wait_cnt   <= wait_cnt_d;
      inc        <= inc_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register
  // in the same cycle the FSM occupies that state.
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_idx_d  = bit_idx;
    wait_cnt_d = wait_cnt;

    case (state)
      ST_IDLE: begin
        if (en) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        // dv wins over a coincident timeout.
        if (dv) begin
          shift_d = q;
          state_d = ST_START;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = ST_REQ;
        end else begin
          wait_cnt_d = wait_cnt + WW'(1);
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) state_d = en ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Align the bit timer with the first start-bit cycle.
    restart      = (state_d == ST_START) && (state != ST_START);
    inc_d        = (state_d == ST_REQ);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state == ST_STOP) && tick_next;

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_usb_status_uart_tx.sv
// Self-checking bench for usb_status_uart_tx: annunciator model plus an
// expected-waveform model built from the 8N1 frame rules.
module tb_usb_status_uart_tx;

  localparam int DIV     = 417;   // round(48e6 / 115200)
  localparam int TIMEOUT = 16;
  localparam int FRAME   = 10 * DIV;

  logic       clk48 = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic       dv    = 1'b0;
  logic [7:0] q     = 8'h00;
  logic       inc, tx, busy, frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q[$];
  bit resp_en  = 1'b1;
  bit prev_inc = 1'b0;
  bit stray_dv = 1'b0;

  usb_status_uart_tx #(
    .CLK_HZ (48000000),
    .BAUD   (115200),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk48     (clk48),
    .rst       (rst),
    .en        (en),
    .q         (q),
    .dv        (dv),
    .inc       (inc),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #10 clk48 = ~clk48;

  // Advance one cycle; annunciator answers an inc seen last cycle with dv.
  task automatic step();
    @(posedge clk48);
    #1;
    if (resp_en && prev_inc) begin
      dv = 1'b1;
      if (byte_q.size() > 0) q = byte_q.pop_front();
      else q = 8'($urandom);
    end else if (stray_dv) begin
      dv = 1'b1;
      q = 8'hFF;
      stray_dv = 1'b0;
    end else begin
      dv = 1'b0;
      q = 8'($urandom);
    end
    prev_inc = inc;
  endtask

  task automatic idle_check(input int cycles, input string name);
    int bad_tx = 0, bad_inc = 0, bad_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (tx !== 1'b1) bad_tx++;
      if (inc !== 1'b0) bad_inc++;
      if (busy !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_tx !== 0) begin errors++; $display("FAIL %s_tx: tx not high in %0d cycles, expected 0", name, bad_tx); end
    checks++;
    if (bad_inc !== 0) begin errors++; $display("FAIL %s_inc: inc high in %0d cycles, expected 0", name, bad_inc); end
    checks++;
    if (bad_busy !== 0) begin errors++; $display("FAIL %s_busy: busy high in %0d cycles, expected 0", name, bad_busy); end
  endtask

  // Wait for inc, then check a whole frame against {stop, data LSB first, start}.
  task automatic run_frame(input logic [7:0] exp, input int drop_k, input int stray_k);
    int n = 0;
    int matched;
    int fd_cnt = 0, fd_pos = -1, busy_cnt = 0, inc_cnt = 0;
    logic [9:0] frame_bits;
    frame_bits = {1'b1, exp, 1'b0};
    while (inc !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (inc !== 1'b1) begin
      errors++;
      $display("FAIL frame_req: inc=%b after %0d cycles, expected 1", inc, n);
      return;
    end
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      matched = 0;
      for (int c = 0; c < DIV; c++) begin
        if (k != 0 || c != 0) step();
        if (k == drop_k && c == 0) en = 1'b0;
        if (k == stray_k && c == DIV / 2) stray_dv = 1'b1;
        if (tx === frame_bits[k]) matched++;
        if (busy === 1'b1) busy_cnt++;
        if (inc !== 1'b0) inc_cnt++;
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_pos = k * DIV + c + 1;
        end
      end
      checks++;
      if (matched != DIV) begin
        errors++;
        $display("FAIL frame_bit%0d (byte %h): tx matched %0d cycles, expected %0d", k, exp, matched, DIV);
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_pos != FRAME) begin
      errors++;
      $display("FAIL frame_done: %0d pulses, last at cycle %0d, expected 1 at %0d", fd_cnt, fd_pos, FRAME);
    end
    checks++;
    if (busy_cnt != FRAME) begin
      errors++;
      $display("FAIL frame_busy: busy high %0d cycles, expected %0d", busy_cnt, FRAME);
    end
    checks++;
    if (inc_cnt != 0) begin
      errors++;
      $display("FAIL frame_inc: inc high %0d cycles in frame, expected 0", inc_cnt);
    end
  endtask

  task automatic check_next_inc(input string name);
    step();
    checks++;
    if (inc !== 1'b1) begin
      errors++;
      $display("FAIL %s: inc=%b after frame_done, expected 1", name, inc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    dv  = 1'b1;
    q   = 8'h41;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (inc !== 1'b0) begin errors++; $display("FAIL reset_inc: got %b expected 0", inc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    idle_check(5000, "reset_idle");
  endtask

  task automatic test_single_a();
    logic [7:0] r1, r2;
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    byte_q = '{8'h41, r1, r2};
    en = 1'b1;
    run_frame(8'h41, -1, -1);
    check_next_inc("a_next_inc");
    run_frame(r1, -1, -1);
    check_next_inc("rand_next_inc");
    run_frame(r2, 0, -1);
    idle_check(300, "a_after");
  endtask

  task automatic test_back_to_back();
    byte_q = '{8'h0C, 8'h41, 8'h42};
    en = 1'b1;
    run_frame(8'h0C, -1, -1);
    check_next_inc("ff_next_inc");
    run_frame(8'h41, 3, -1);
    idle_check(300, "b2b_after");
    checks++;
    if (byte_q.size() != 1) begin
      errors++;
      $display("FAIL b2b_left: %0d bytes unrequested, expected 1", byte_q.size());
    end
    byte_q.delete();
  endtask

  task automatic test_timeout();
    int n = 0;
    int bad_tx = 0, bad_busy = 0;
    logic [7:0] b;
    resp_en = 1'b0;
    en = 1'b1;
    while (inc !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (inc !== 1'b1) begin errors++; $display("FAIL to_first_inc: inc=%b expected 1", inc); end
    for (int p = 0; p < 5; p++) begin
      n = 0;
      do begin
        step();
        n++;
        if (tx !== 1'b1) bad_tx++;
        if (busy !== 1'b1) bad_busy++;
      end while (inc !== 1'b1 && n < 100);
      checks++;
      if (n != TIMEOUT + 1) begin
        errors++;
        $display("FAIL to_period%0d: %0d cycles between inc, expected %0d", p, n, TIMEOUT + 1);
      end
    end
    checks++;
    if (bad_tx != 0 || bad_busy != 0) begin
      errors++;
      $display("FAIL to_lines: tx low %0d / busy low %0d cycles, expected 0 / 0", bad_tx, bad_busy);
    end
    b = 8'($urandom);
    resp_en = 1'b1;
    byte_q = '{b};
    en = 1'b0;
    run_frame(b, -1, -1);
    idle_check(100, "to_after");
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    logic [7:0] b1, b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    byte_q = '{b1, b2};
    en = 1'b1;
    while (inc !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    repeat (2 + 4 * DIV + DIV / 2) step();
    checks++;
    if (tx !== b1[3]) begin errors++; $display("FAIL rmf_bit3: tx=%b expected %b", tx, b1[3]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rmf_tx: got %b expected 1", tx); end
    checks++;
    if (inc !== 1'b0) begin errors++; $display("FAIL rmf_inc: got %b expected 0", inc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy); end
    step();
    checks++;
    if (inc !== 1'b1) begin errors++; $display("FAIL rmf_fresh_inc: got %b expected 1", inc); end
    run_frame(b2, 0, -1);
    idle_check(100, "rmf_after");
  endtask

  task automatic test_stray_dv();
    logic [7:0] b;
    b = 8'($urandom);
    byte_q = '{b};
    en = 1'b1;
    run_frame(b, 0, 5);
    idle_check(300, "stray_after");
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_stray_dv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
